// File: rtl/sound_mixer.sv
// rtl/sound_mixer.sv - multi-channel ROM sample mixer with a fixed-latency sequential mix
// Define SOUND_MIXER_SATURATE_EN to clamp the final mix instead of wrapping it.
module sound_mixer #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 15,
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sample_req,
  output logic [DATA_W-1:0]        audio_output,
  output logic [ADDR_W-1:0]        rom_addr,
  input  logic [DATA_W-1:0]        rom_data,
  input  logic [NUM_CH*ADDR_W-1:0] ch_base,
  input  logic [NUM_CH*ADDR_W-1:0] ch_len,
  input  logic [NUM_CH-1:0]        ch_start,
  input  logic [NUM_CH-1:0]        ch_stop,
  input  logic [NUM_CH-1:0]        ch_loop,
  output logic [NUM_CH-1:0]        ch_active,
  output logic                     overrun
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int ACC_W = DATA_W + 3;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  typedef enum logic [2:0] {IDLE, ADDR, WAIT, DATA, OUT} state_t;
  state_t state, state_nxt;

  logic [CH_W-1:0]         ch;
  logic signed [ACC_W-1:0] acc;
  logic [ADDR_W-1:0]       pos [NUM_CH];
  logic [NUM_CH-1:0]       pend_start, pend_stop, eff_start, eff_stop;
  logic                    accept;
  logic [ADDR_W-1:0]       cur_base, cur_len, cur_pos;
  logic [DATA_W-1:0]       mix_out;

  assign accept    = (state == IDLE) && sample_req;
  // Pulses arriving in the accepting cycle itself are honoured for this sample.
  assign eff_start = pend_start | ch_start;
  assign eff_stop  = pend_stop | ch_stop;
  assign cur_base  = ch_base[ch*ADDR_W +: ADDR_W];
  assign cur_len   = ch_len[ch*ADDR_W +: ADDR_W];
  assign cur_pos   = pos[ch];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sample_req) state_nxt = ADDR;
      ADDR:    state_nxt = WAIT;
      WAIT:    state_nxt = DATA;
      DATA:    state_nxt = (ch == LAST_CH) ? OUT : ADDR;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef SOUND_MIXER_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {4'b0000, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {4'b1111, {(DATA_W-1){1'b0}}};
  always_comb begin
    if (acc > SAT_MAX)      mix_out = {1'b0, {(DATA_W-1){1'b1}}};
    else if (acc < SAT_MIN) mix_out = {1'b1, {(DATA_W-1){1'b0}}};
    else                    mix_out = acc[DATA_W-1:0];
  end
`else
  assign mix_out = acc[DATA_W-1:0];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ch           <= '0;
      acc          <= '0;
      audio_output <= '0;
      rom_addr     <= '0;
      overrun      <= 1'b0;
    end else begin
      if (sample_req && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: if (sample_req) begin
          acc <= '0;
          ch  <= '0;
        end
        ADDR: rom_addr <= cur_base + cur_pos;
        DATA: begin
          if (ch_active[ch]) acc <= acc + $signed({{3{rom_data[DATA_W-1]}}, rom_data});
          if (ch != LAST_CH) ch <= ch + 1'b1;
        end
        OUT: audio_output <= mix_out;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_start <= '0;
      pend_stop  <= '0;
    end else if (accept) begin
      pend_start <= '0;
      pend_stop  <= '0;
    end else begin
      pend_start <= eff_start;
      pend_stop  <= eff_stop;
    end
  end

  // Start beats stop; a zero-length start leaves the channel as it was.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ch_active <= '0;
      for (int c = 0; c < NUM_CH; c++) pos[c] <= '0;
    end else if (accept) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (eff_start[c] && ch_len[c*ADDR_W +: ADDR_W] != '0) begin
          pos[c]       <= '0;
          ch_active[c] <= 1'b1;
        end else if (eff_stop[c]) begin
          ch_active[c] <= 1'b0;
        end
      end
    end else if (state == DATA && ch_active[ch]) begin
      if (cur_pos == cur_len - 1'b1) begin
        pos[ch]       <= '0;
        ch_active[ch] <= ch_loop[ch];
      end else begin
        pos[ch] <= cur_pos + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sound_mixer.sv
// tb/tb_sound_mixer.sv - directed and randomized checks of sound_mixer against a per-request model
// Expected mixes honour SOUND_MIXER_SATURATE_EN the same way the design build does.
module tb_sound_mixer;
  localparam int NUM_CH = 4;
  localparam int ADDR_W = 15;
  localparam int DATA_W = 16;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     sample_req;
  logic [DATA_W-1:0]        audio_output;
  logic [ADDR_W-1:0]        rom_addr;
  logic [DATA_W-1:0]        rom_data;
  logic [NUM_CH*ADDR_W-1:0] ch_base;
  logic [NUM_CH*ADDR_W-1:0] ch_len;
  logic [NUM_CH-1:0]        ch_start;
  logic [NUM_CH-1:0]        ch_stop;
  logic [NUM_CH-1:0]        ch_loop;
  logic [NUM_CH-1:0]        ch_active;
  logic                     overrun;

  sound_mixer #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .sample_req(sample_req), .audio_output(audio_output),
    .rom_addr(rom_addr), .rom_data(rom_data), .ch_base(ch_base), .ch_len(ch_len),
    .ch_start(ch_start), .ch_stop(ch_stop), .ch_loop(ch_loop), .ch_active(ch_active),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  logic [15:0] rom [0:32767];
  always @(posedge clk) rom_data <= rom[rom_addr];

  int total = 0;
  int bad = 0;
  int  mbase [NUM_CH];
  int  mlen  [NUM_CH];
  int  mpos  [NUM_CH];
  bit  mloop [NUM_CH];
  bit  mact  [NUM_CH];
  bit  mps   [NUM_CH];
  bit  mpst  [NUM_CH];
  logic [15:0] exp_audio;
  bit exp_ovr;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [3:0] act_vec();
    logic [3:0] v;
    for (int c = 0; c < NUM_CH; c++) v[c] = mact[c];
    return v;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      mpos[c] = 0; mact[c] = 0; mps[c] = 0; mpst[c] = 0;
    end
    exp_audio = 16'h0;
    exp_ovr = 0;
  endtask

  task automatic set_cfg(input int c, input int base, input int len, input bit lp);
    mbase[c] = base; mlen[c] = len; mloop[c] = lp;
    ch_base[c*ADDR_W +: ADDR_W] = ADDR_W'(base);
    ch_len[c*ADDR_W +: ADDR_W]  = ADDR_W'(len);
    ch_loop[c] = lp;
  endtask

  task automatic pulse(input logic [3:0] sm, input logic [3:0] pm);
    ch_start = sm; ch_stop = pm;
    tick();
    ch_start = '0; ch_stop = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (sm[c]) mps[c] = 1;
      if (pm[c]) mpst[c] = 1;
    end
  endtask

  // One full sample request; the new sample is expected 14 cycles after the pulse rises.
  task automatic mix(input int ovr_at, input logic [3:0] mid_start, input logic [3:0] mid_stop);
    int sum;
    int addr [NUM_CH];
    logic [15:0] expo, prev;
    prev = exp_audio;
    for (int c = 0; c < NUM_CH; c++) begin
      if (mps[c] && mlen[c] != 0) begin mpos[c] = 0; mact[c] = 1; end
      else if (mpst[c]) mact[c] = 0;
      mps[c] = 0; mpst[c] = 0;
    end
    sum = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      addr[c] = (mbase[c] + mpos[c]) % 32768;
      if (mact[c]) begin
        sum = sum + int'($signed(rom[addr[c]]));
        if (mpos[c] == mlen[c] - 1) begin mpos[c] = 0; mact[c] = mloop[c]; end
        else mpos[c] = mpos[c] + 1;
      end
    end
`ifdef SOUND_MIXER_SATURATE_EN
    if (sum > 32767)       expo = 16'h7fff;
    else if (sum < -32768) expo = 16'h8000;
    else                   expo = sum[15:0];
`else
    expo = sum[15:0];
`endif
    sample_req = 1'b1;
    tick();
    sample_req = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      if (k == ovr_at) sample_req = 1'b1;
      if (k == 6) begin ch_start = mid_start; ch_stop = mid_stop; end
      tick();
      sample_req = 1'b0;
      ch_start = '0; ch_stop = '0;
      if (k % 3 == 1 && (k - 1) / 3 < NUM_CH) chk("rom_addr", rom_addr, addr[(k-1)/3]);
      if (k == 12) chk("audio_hold", audio_output, prev);
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (mid_start[c]) mps[c] = 1;
      if (mid_stop[c]) mpst[c] = 1;
    end
    if (ovr_at != 0) exp_ovr = 1;
    exp_audio = expo;
    chk("audio", audio_output, expo);
    chk("active", ch_active, act_vec());
    chk("overrun", overrun, exp_ovr);
  endtask

  initial begin
    reset = 1'b1; sample_req = 1'b0;
    ch_start = '0; ch_stop = '0; ch_base = '0; ch_len = '0; ch_loop = '0;
    for (int i = 0; i < 32768; i++) rom[i] = 16'($urandom);
    for (int c = 0; c < NUM_CH; c++) begin mbase[c] = 0; mlen[c] = 0; mloop[c] = 0; end
    model_reset();
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_audio", audio_output, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_active", ch_active, 0);
    chk("rst_overrun", overrun, 0);

    // Silence: every channel idle, ROM addresses still walk the bases.
    set_cfg(0, 'h0010, 5, 0);
    set_cfg(1, 'h0200, 5, 0);
    set_cfg(2, 'h3000, 5, 0);
    set_cfg(3, 'h7ff0, 5, 0);
    mix(0, 0, 0);
    chk("silence", audio_output, 0);

    // One-shot playback of three words.
    set_cfg(0, 'h100, 3, 0);
    rom['h100] = 16'd10; rom['h101] = 16'd20; rom['h102] = 16'd30;
    pulse(4'b0001, 4'b0000);
    mix(0, 0, 0); chk("oneshot0", audio_output, 10);
    mix(0, 0, 0); chk("oneshot1", audio_output, 20);
    mix(0, 0, 0); chk("oneshot2", audio_output, 30);
    chk("oneshot_done", ch_active[0], 0);
    mix(0, 0, 0); chk("oneshot3", audio_output, 0);

    // Looping playback.
    set_cfg(0, 'h100, 3, 1);
    pulse(4'b0001, 4'b0000);
    mix(0, 0, 0); chk("loop0", audio_output, 10);
    mix(0, 0, 0); chk("loop1", audio_output, 20);
    mix(0, 0, 0); chk("loop2", audio_output, 30);
    mix(0, 0, 0); chk("loop3", audio_output, 10);
    mix(0, 0, 0); chk("loop4", audio_output, 20);
    chk("loop_active", ch_active[0], 1);
    pulse(4'b0000, 4'b0001);
    mix(0, 0, 0); chk("stopped", audio_output, 0);

    // Large positive and negative sums.
    for (int c = 0; c < NUM_CH; c++) begin
      set_cfg(c, 'h400 + c * 'h100, 2, 1);
      rom['h400 + c * 'h100] = 16'h7000;
      rom['h401 + c * 'h100] = 16'h9000;
    end
    pulse(4'b1111, 4'b0000);
    mix(0, 0, 0);
`ifdef SOUND_MIXER_SATURATE_EN
    chk("sat_pos", audio_output, 'h7fff);
`else
    chk("wrap_pos", audio_output, 'hc000);
`endif
    mix(0, 0, 0);
`ifdef SOUND_MIXER_SATURATE_EN
    chk("sat_neg", audio_output, 'h8000);
`else
    chk("wrap_neg", audio_output, 'h4000);
`endif
    pulse(4'b0000, 4'b1111);
    mix(0, 0, 0);

    // Overrun during a mix, and start+stop together restarting from the first word.
    chk("no_overrun_yet", overrun, 0);
    set_cfg(1, 'h800, 4, 1);
    rom['h800] = 16'd1; rom['h801] = 16'd2; rom['h802] = 16'd3; rom['h803] = 16'd4;
    pulse(4'b0010, 4'b0000);
    mix(0, 0, 0); chk("ch1_w0", audio_output, 1);
    mix(0, 0, 0); chk("ch1_w1", audio_output, 2);
    mix(4, 4'b0010, 4'b0010); chk("ovr_result", audio_output, 3);
    chk("overrun_set", overrun, 1);
    mix(0, 0, 0); chk("ch1_restart", audio_output, 1);
    chk("ch1_active", ch_active[1], 1);

    // Reset in the middle of a mix.
    sample_req = 1'b1;
    tick();
    sample_req = 1'b0;
    repeat (6) tick();
    reset = 1'b1;
    #1;
    chk("async_rst_audio", audio_output, 0);
    chk("async_rst_active", ch_active, 0);
    tick();
    reset = 1'b0;
    model_reset();
    repeat (12) tick();
    chk("abort_audio", audio_output, 0);
    chk("abort_active", ch_active, 0);
    chk("abort_overrun", overrun, 0);
    mix(0, 0, 0);
    chk("after_abort", audio_output, 0);

    // Randomized configurations, starts and stops.
    for (int it = 0; it < 40; it++) begin
      int c;
      logic [3:0] sm, pm;
      c  = $urandom_range(0, NUM_CH - 1);
      sm = '0;
      pm = 4'($urandom) & 4'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        set_cfg(c, $urandom_range(0, 32767), $urandom_range(0, 6), 1'($urandom_range(0, 1)));
        sm[c] = 1'b1;
      end
      pulse(sm, pm);
      mix(0, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sound_mixer.md
SOUND_MIXER -- requirements
Module: sound_mixer

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning number of sound channels (1..8).
REQ-002 SHALL have parameter ADDR_W, default 15, meaning shared sound-ROM address width.
REQ-003 SHALL have parameter DATA_W, default 16, meaning signed sample width.
REQ-004 clk  input  1  audio clock; all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 sample_req  input  1  one-cycle codec pulse requesting the next mixed sample.
REQ-007 audio_output  output  DATA_W  mixed signed sample to codec, registered.
REQ-008 rom_addr  output  ADDR_W  registered address to the shared synchronous sound ROM.
REQ-009 rom_data  input  DATA_W  ROM word, valid the cycle after rom_addr is presented.
REQ-010 ch_base  input  NUM_CH*ADDR_W  per-channel start address, channel c at bits [c*ADDR_W +: ADDR_W].
REQ-011 ch_len  input  NUM_CH*ADDR_W  per-channel length in words, same packing.
REQ-012 ch_start  input  NUM_CH  per-channel start pulse from the Avalon register block.
REQ-013 ch_stop  input  NUM_CH  per-channel stop pulse.
REQ-014 ch_loop  input  NUM_CH  per-channel loop-mode level.
REQ-015 ch_active  output  NUM_CH  per-channel playing status.
REQ-016 overrun  output  1  sticky flag: sample_req arrived while a mix was in progress.

Function
REQ-017 FSM states: IDLE, ADDR, WAIT, DATA, OUT; channel index ch walks 0..NUM_CH-1 through ADDR->WAIT->DATA.
REQ-018 IDLE + sample_req: apply pending start/stop bits, clear accumulator, ch=0, go ADDR.
REQ-019 ADDR: rom_addr <= ch_base[ch] + pos[ch] (modulo 2^ADDR_W); go WAIT.
REQ-020 WAIT: go DATA (ROM read latency cycle).
REQ-021 DATA: if ch_active[ch], accumulator += sign-extended rom_data and advance pos[ch]; else add 0.
REQ-022 DATA: if ch==NUM_CH-1 go OUT, else ch+1 and go ADDR.
REQ-023 Inactive channels SHALL still traverse ADDR/WAIT/DATA so latency is fixed.
REQ-024 OUT: audio_output <= final mix (see REQ-034/035); go IDLE.
REQ-025 audio_output SHALL update exactly 3*NUM_CH+2 cycles after the accepting sample_req edge and hold until the next update.
REQ-026 Accumulator width SHALL be DATA_W+3 bits, signed; no intermediate overflow for NUM_CH<=8.
REQ-027 Position advance: pos==len-1 -> pos=0; channel stays active if ch_loop[ch]=1, else goes inactive.
REQ-028 ch_start/ch_stop pulses SHALL be captured in pending registers in any state and applied only at REQ-018.
REQ-029 Pending start sets pos=0 and active=1, restarting a playing channel; start wins over simultaneous stop.
REQ-030 Start with ch_len==0 SHALL be ignored (channel stays inactive).
REQ-031 sample_req outside IDLE SHALL be ignored and SHALL set overrun; overrun clears only on reset.

Reset
REQ-032 reset SHALL asynchronously force state IDLE, ch=0, accumulator=0, audio_output=0, rom_addr=0, all pos=0, ch_active=0, pending bits=0, overrun=0.
REQ-033 reset asserted mid-mix SHALL abort the mix with no audio_output update; first sample after release is computed from silence.

Configuration
REQ-034 With SOUND_MIXER_SATURATE_EN defined, OUT SHALL clamp the accumulator to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-035 Without SOUND_MIXER_SATURATE_EN, OUT SHALL take the low DATA_W accumulator bits (two's-complement wrap).

Verification
REQ-036 Reset, no starts, sample_req -> audio_output=0 after 14 cycles (NUM_CH=4), ch_active=0000, rom_addr sequence = ch_base values.
REQ-037 ch0 base=0x100 len=3 loop=0, ROM[0x100..0x102]=10,20,30, start ch0 + 4 reqs -> outputs 10,20,30,0; ch_active[0] falls after third req.
REQ-038 Same with loop=1 -> outputs 10,20,30,10,20; ch_active[0] remains 1.
REQ-039 All 4 channels return 0x7000 -> SATURATE_EN output 0x7FFF; without macro output 0xC000.
REQ-040 Second sample_req 5 cycles after first -> ignored, overrun=1, first result still arrives at cycle 14; start+stop same cycle on ch1 -> ch1 plays from pos 0.
REQ-041 reset pulse at cycle 7 of a mix -> audio_output stays 0, ch_active=0000, next req yields 0.
